// File: rtl/lif_acc_pkg.sv
// rtl/lif_acc_pkg.sv - shared types and helpers for the spike ingress encoder
package lif_acc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  // Widest spike word the helper functions accept; narrower words are zero-extended.
  localparam int MAX_LANES = 256;

  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lowest_set_idx(input logic [MAX_LANES-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic popcnt_le1(input logic [MAX_LANES-1:0] v);
    return (v & (v - MAX_LANES'(1))) == '0;
  endfunction

endpackage

// File: rtl/spike_word_fifo.sv
// rtl/spike_word_fifo.sv - synchronous word FIFO with flush and occupancy level
module spike_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign level_o   = r_wr_ptr - r_rd_ptr;
  assign full_o    = (level_o == LW'(DEPTH));
  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign rdata_o   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = push_i && !full_o && !flush_i;
  assign w_do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer update; flush empties the FIFO without touching storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Word storage, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spike_ingress_encoder.sv
// rtl/spike_ingress_encoder.sv - buffers spike vectors and streams active spike indices
module spike_ingress_encoder import lif_acc_pkg::*; #(
  parameter int NUM_LANES  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int EMIT_EMPTY = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                in_req_i,
  input  logic [NUM_LANES-1:0]                in_rdata_bi,
  output logic                                in_ack_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [idx_width(NUM_LANES)-1:0]     out_idx_o,
  output logic                                out_last_o,
  output logic                                out_none_o,
  output logic [level_width(FIFO_DEPTH)-1:0]  level_o
);

  localparam int IDX_W = idx_width(NUM_LANES);

  enc_state_e           r_state;
  enc_state_e           w_state_nxt;
  logic [NUM_LANES-1:0] r_mask;
  logic [NUM_LANES-1:0] w_mask_nxt;
  logic                 r_ack;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [NUM_LANES-1:0] w_head;
  logic                 w_head_skip;
  logic                 w_last;
  logic [MAX_LANES-1:0] w_mask_ext;

  // A req seen while ack is high belongs to the word just taken, so it is ignored.
  assign w_push      = in_req_i && !r_ack && !w_full && !flush_i;
  assign w_head_skip = (w_head == '0) && (EMIT_EMPTY == 0);
  assign w_mask_ext  = MAX_LANES'(r_mask);
  assign w_last      = popcnt_le1(w_mask_ext);

  spike_word_fifo #(
    .WIDTH (NUM_LANES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push),
    .wdata_i (in_rdata_bi),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  // Acceptance pulse: high for the single cycle after a capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_ack <= 1'b0;
    else       r_ack <= w_push;
  end

  // Encoder state and remaining-spike mask.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  // Next-state: load a head word when idle or right after a last beat, else strip one bit.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_pop       = 1'b0;
    if (flush_i) begin
      w_state_nxt = IDLE;
      w_mask_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_mask_nxt  = w_head;
            w_state_nxt = w_head_skip ? IDLE : EMIT;
          end
        end
        EMIT: begin
          if (out_ready_i) begin
            if (w_last) begin
              if (!w_empty) begin
                w_pop       = 1'b1;
                w_mask_nxt  = w_head;
                w_state_nxt = w_head_skip ? IDLE : EMIT;
              end else begin
                w_mask_nxt  = '0;
                w_state_nxt = IDLE;
              end
            end else begin
              w_mask_nxt = r_mask & (r_mask - NUM_LANES'(1));
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_mask_nxt  = '0;
        end
      endcase
    end
  end

  assign in_ack_o    = r_ack;
  assign out_valid_o = (r_state == EMIT);
  assign out_idx_o   = out_valid_o ? IDX_W'(lowest_set_idx(w_mask_ext)) : '0;
  assign out_last_o  = out_valid_o && w_last;
  assign out_none_o  = out_valid_o && (r_mask == '0);

endmodule
